// File: rtl/hanoi_prog_loader.sv
// Program-memory writer for the Hanoi interpreter.
// Validates an incoming token stream (legal codes, balanced loops, length limit),
// writes accepted tokens, then pads the remainder of memory with the NOP trap token.
module hanoi_prog_loader #(
    parameter int unsigned PROG_SIZE = 8,
    parameter int unsigned ADDR_W    = $clog2(PROG_SIZE + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_tok,
    input  logic              in_last,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [2:0]        wr_tok,
    output logic              done,
    output logic              ok,
    output logic [1:0]        err_code,
    output logic [ADDR_W-1:0] prog_len
);

    localparam logic [2:0] TokLoopBegin = 3'd3;
    localparam logic [2:0] TokLoopEnd   = 3'd4;
    localparam logic [2:0] TokSwap      = 3'd5;
    localparam logic [2:0] TokNop       = 3'd6;

    localparam logic [1:0] ErrBadTok     = 2'd0;
    localparam logic [1:0] ErrUnderflow  = 2'd1;
    localparam logic [1:0] ErrOverflow   = 2'd2;
    localparam logic [1:0] ErrUnbalanced = 2'd3;

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(PROG_SIZE - 1);
    localparam logic [ADDR_W-1:0] ProgEnd = ADDR_W'(PROG_SIZE);

    typedef enum logic [2:0] {StIdle, StLoad, StPad, StDone, StErr} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0] depth_q, depth_d;
    logic              in_ready_q, in_ready_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [2:0]        wr_tok_q, wr_tok_d;
    logic              done_q, done_d;
    logic              ok_q, ok_d;
    logic [1:0]        err_q, err_d;
    logic [ADDR_W-1:0] prog_len_q, prog_len_d;

    logic              accept;
    logic [ADDR_W-1:0] depth_post;

    assign accept = in_valid && in_ready_q;

    // Loop depth as it would be after the current input token.
    always_comb begin
        depth_post = depth_q;
        if (in_tok == TokLoopBegin) begin
            depth_post = depth_q + 1'b1;
        end else if (in_tok == TokLoopEnd) begin
            depth_post = depth_q - 1'b1;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        depth_d    = depth_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_tok_d   = wr_tok_q;
        done_d     = done_q;
        ok_d       = ok_q;
        err_d      = err_q;
        prog_len_d = prog_len_q;

        if (start) begin
            // Restart wins over everything, including a coincident token or pad write.
            state_d = StLoad;
            count_d = '0;
            depth_d = '0;
            done_d  = 1'b0;
            ok_d    = 1'b0;
            err_d   = ErrBadTok;
        end else begin
            unique case (state_q)
                StLoad: begin
                    if (accept) begin
                        if (in_tok > TokSwap) begin
                            state_d = StErr;
                            done_d  = 1'b1;
                            err_d   = ErrBadTok;
                        end else if (in_tok == TokLoopEnd && depth_q == '0) begin
                            state_d = StErr;
                            done_d  = 1'b1;
                            err_d   = ErrUnderflow;
                        end else if (count_q == LastIdx && !in_last) begin
                            state_d = StErr;
                            done_d  = 1'b1;
                            err_d   = ErrOverflow;
                        end else if (in_last && depth_post != '0) begin
                            state_d = StErr;
                            done_d  = 1'b1;
                            err_d   = ErrUnbalanced;
                        end else begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = count_q;
                            wr_tok_d  = in_tok;
                            count_d   = count_q + 1'b1;
                            depth_d   = depth_post;
                            if (in_last) begin
                                prog_len_d = count_q + 1'b1;
                                state_d    = StPad;
                            end
                        end
                    end
                end
                StPad: begin
                    // count walks from prog_len up to PROG_SIZE, one NOP per cycle.
                    wr_en_d   = 1'b1;
                    wr_addr_d = count_q;
                    wr_tok_d  = TokNop;
                    count_d   = count_q + 1'b1;
                    if (count_q == ProgEnd) begin
                        state_d = StDone;
                    end
                end
                StDone: begin
                    done_d = 1'b1;
                    ok_d   = 1'b1;
                end
                StErr: begin
                    done_d = 1'b1;
                    ok_d   = 1'b0;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        in_ready_d = (state_d == StLoad);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            count_q    <= '0;
            depth_q    <= '0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_tok_q   <= '0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            err_q      <= '0;
            prog_len_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            depth_q    <= depth_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_tok_q   <= wr_tok_d;
            done_q     <= done_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
            prog_len_q <= prog_len_d;
        end
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_tok   = wr_tok_q;
    assign done     = done_q;
    assign ok       = ok_q;
    assign err_code = err_q;
    assign prog_len = prog_len_q;

endmodule

// File: tb/tb_hanoi_prog_loader.sv
// Directed bench for hanoi_prog_loader: logs every memory write and checks
// sequences, status and timing against hand-computed expectations.
module tb_hanoi_prog_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_tok = '0;
    logic       in_last = 1'b0;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [2:0] wr_tok;
    logic       done;
    logic       ok;
    logic [1:0] err_code;
    logic [3:0] prog_len;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    int log_addr[$];
    int log_tok[$];
    int log_cyc[$];

    hanoi_prog_loader #(.PROG_SIZE(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_tok   (in_tok),
        .in_last  (in_last),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_tok   (wr_tok),
        .done     (done),
        .ok       (ok),
        .err_code (err_code),
        .prog_len (prog_len)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_en) begin
            log_addr.push_back(int'(wr_addr));
            log_tok.push_back(int'(wr_tok));
            log_cyc.push_back(cyc);
        end
    end

    task automatic clear_log();
        log_addr.delete();
        log_tok.delete();
        log_cyc.delete();
    endtask

    task automatic do_start();
        @(negedge clk);
        clear_log();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present a token and hold it until the loader takes it.
    task automatic send(input logic [2:0] t, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_tok   = t;
        in_last  = l;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL send_ready: in_ready=%b required 1 (tok %0d)", in_ready, t);
        end
        @(negedge clk);
    endtask

    task automatic wait_done(output int done_cyc);
        int n;
        n = 0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        done_cyc = cyc;
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL wait_done: done=%b required 1 within 40 cycles", done);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_tok   = 3'd3;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        total++;
        if ({in_ready, wr_en, done, ok} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags: ready,wr_en,done,ok=%b required 0000",
                     {in_ready, wr_en, done, ok});
        end
        total++;
        if ({err_code, prog_len, wr_addr, wr_tok} !== 13'd0) begin
            bad++;
            $display("FAIL reset_values: err=%0d len=%0d addr=%0d tok=%0d required all 0",
                     err_code, prog_len, wr_addr, wr_tok);
        end
        total++;
        if (log_addr.size() !== 0) begin
            bad++;
            $display("FAIL reset_no_write: writes=%0d required 0", log_addr.size());
        end
        in_valid = 1'b0;
    endtask

    task automatic test_basic();
        int dc;
        int exp_tok[9] = '{3, 2, 4, 6, 6, 6, 6, 6, 6};
        do_start();
        send(3'd3, 1'b0);
        send(3'd2, 1'b0);
        send(3'd4, 1'b1);
        wait_done(dc);
        total++;
        if (log_addr.size() !== 9) begin
            bad++;
            $display("FAIL basic_count: writes=%0d required 9", log_addr.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                total++;
                if (log_addr[i] !== i || log_tok[i] !== exp_tok[i] ||
                    log_cyc[i] !== log_cyc[0] + i) begin
                    bad++;
                    $display("FAIL basic_write%0d: addr=%0d tok=%0d cyc=%0d required %0d %0d %0d",
                             i, log_addr[i], log_tok[i], log_cyc[i], i, exp_tok[i],
                             log_cyc[0] + i);
                end
            end
            total++;
            if (dc !== log_cyc[8] + 1) begin
                bad++;
                $display("FAIL basic_done_time: done cycle=%0d required %0d", dc, log_cyc[8] + 1);
            end
        end
        total++;
        if (ok !== 1'b1 || prog_len !== 4'd3) begin
            bad++;
            $display("FAIL basic_status: ok=%b len=%0d required 1 3", ok, prog_len);
        end
    endtask

    task automatic test_bad_first(input logic [2:0] t, input logic [1:0] code);
        int dc;
        do_start();
        send(t, 1'b0);
        wait_done(dc);
        repeat (2) @(negedge clk);
        total++;
        if (ok !== 1'b0 || err_code !== code || log_addr.size() !== 0) begin
            bad++;
            $display("FAIL bad_first_tok%0d: ok=%b err=%0d writes=%0d required 0 %0d 0",
                     t, ok, err_code, log_addr.size(), code);
        end
    endtask

    task automatic test_full(input logic with_last);
        int dc;
        do_start();
        for (int i = 0; i < 7; i++) send(3'd0, 1'b0);
        send(3'd0, with_last);
        wait_done(dc);
        repeat (2) @(negedge clk);
        if (with_last) begin
            total++;
            if (log_addr.size() !== 9 || ok !== 1'b1 || prog_len !== 4'd8) begin
                bad++;
                $display("FAIL full_status: writes=%0d ok=%b len=%0d required 9 1 8",
                         log_addr.size(), ok, prog_len);
            end else begin
                total++;
                if (log_addr[7] !== 7 || log_tok[7] !== 0 ||
                    log_addr[8] !== 8 || log_tok[8] !== 6) begin
                    bad++;
                    $display("FAIL full_tail: (%0d,%0d)(%0d,%0d) required (7,0)(8,6)",
                             log_addr[7], log_tok[7], log_addr[8], log_tok[8]);
                end
            end
        end else begin
            total++;
            if (log_addr.size() !== 7 || ok !== 1'b0 || err_code !== 2'd2) begin
                bad++;
                $display("FAIL overflow: writes=%0d ok=%b err=%0d required 7 0 2",
                         log_addr.size(), ok, err_code);
            end
        end
    endtask

    task automatic test_unbalanced();
        int dc;
        do_start();
        send(3'd3, 1'b0);
        send(3'd3, 1'b0);
        send(3'd4, 1'b1);
        wait_done(dc);
        repeat (2) @(negedge clk);
        total++;
        if (ok !== 1'b0 || err_code !== 2'd3 || log_addr.size() !== 2) begin
            bad++;
            $display("FAIL unbalanced: ok=%b err=%0d writes=%0d required 0 3 2",
                     ok, err_code, log_addr.size());
        end else begin
            total++;
            if (log_addr[0] !== 0 || log_tok[0] !== 3 || log_addr[1] !== 1 || log_tok[1] !== 3) begin
                bad++;
                $display("FAIL unbalanced_writes: (%0d,%0d)(%0d,%0d) required (0,3)(1,3)",
                         log_addr[0], log_tok[0], log_addr[1], log_tok[1]);
            end
        end
    endtask

    task automatic test_abort_start();
        int dc;
        do_start();
        send(3'd0, 1'b0);
        send(3'd1, 1'b0);
        // Token and restart on the same edge: restart must win.
        in_valid = 1'b1;
        in_tok   = 3'd5;
        in_last  = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL abort_ready: in_ready=%b required 1", in_ready);
        end
        repeat (2) @(negedge clk);
        total++;
        if (log_addr.size() !== 2 || log_tok[log_addr.size() - 1] !== 1) begin
            bad++;
            $display("FAIL abort_dropped: writes=%0d required 2 ending with tok 1", log_addr.size());
        end
        clear_log();
        send(3'd2, 1'b1);
        wait_done(dc);
        total++;
        if (log_addr.size() !== 9 || log_addr[0] !== 0 || log_tok[0] !== 2 ||
            prog_len !== 4'd1 || ok !== 1'b1) begin
            bad++;
            $display("FAIL abort_reload: writes=%0d first=(%0d,%0d) len=%0d ok=%b required 9 (0,2) 1 1",
                     log_addr.size(), log_addr[0], log_tok[0], prog_len, ok);
        end
    endtask

    task automatic test_reset_in_pad();
        int n;
        do_start();
        send(3'd0, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        n = 0;
        while (!(wr_en && wr_tok == 3'd6) && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!(wr_en === 1'b1 && wr_tok === 3'd6)) begin
            bad++;
            $display("FAIL pad_reached: wr_en=%b tok=%0d required 1 6", wr_en, wr_tok);
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({wr_en, in_ready, done, ok} !== 4'b0000) begin
            bad++;
            $display("FAIL pad_async_reset: wr_en,ready,done,ok=%b required 0000",
                     {wr_en, in_ready, done, ok});
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        repeat (4) @(negedge clk);
        total++;
        if (log_addr.size() !== 0 || in_ready !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL pad_idle: writes=%0d ready=%b done=%b required 0 0 0",
                     log_addr.size(), in_ready, done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_first(3'd4, 2'd1);
        test_bad_first(3'd7, 2'd0);
        test_bad_first(3'd6, 2'd0);
        test_full(1'b1);
        test_full(1'b0);
        test_unbalanced();
        test_abort_start();
        test_reset_in_pad();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hanoi_prog_loader.md
Name: hanoi_prog_loader

Overview:
- Writer side of the Hanoi interpreter's program memory.
- Accepts a token stream over a valid/ready handshake and checks it for well-formedness: legal tokens, balanced loops, fits in PROG_SIZE.
- Writes accepted tokens to program memory, then fills every remaining slot up to index PROG_SIZE with the NOP trap token.
- Reports done/ok; on failure, reports an error code.

Parameters:
- PROG_SIZE, 8: maximum program length in tokens; memory holds PROG_SIZE+1 entries, the last entry always being NOP.
- ADDR_W, $clog2(PROG_SIZE+1): width of addresses and counters (derived; do not override).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; begins a new load, aborting any load in progress.
- in_valid  input  1  token present.
- in_ready  output  1  loader accepts a token this cycle.
- in_tok  input  3  token code: LEFT=0, RIGHT=1, INTERACT=2, LOOP_BEGIN=3, LOOP_END=4, SWAP=5, NOP=6, 7 illegal.
- in_last  input  1  qualifies the final token of the program.
- wr_en  output  1  memory write strobe.
- wr_addr  output  ADDR_W  memory write address.
- wr_tok  output  3  memory write data.
- done  output  1  load finished, either success or error; held high until the next start.
- ok  output  1  valid when done: 1 means the program is well-formed.
- err_code  output  2  valid when done&&!ok: 0 BAD_TOK, 1 UNDERFLOW, 2 OVERFLOW, 3 UNBALANCED.
- prog_len  output  ADDR_W  number of tokens accepted; valid when done&&ok.

Behaviour:
- Reset (async, rst_n low): state IDLE; in_ready, wr_en, done, ok = 0; wr_addr, wr_tok, err_code, prog_len, count, depth = 0.
- States: IDLE, LOAD, PAD, DONE, ERR.
- start in any state:
  - next state LOAD; count=0, depth=0; done=0, ok=0, err_code=0.
  - Any in-flight PAD write is abandoned.
- in_ready = 1 only in LOAD (registered state decode, not combinational on in_valid).
- Accept = in_valid && in_ready. Token is legal if in_tok<=5. NOP as input is illegal, because NOP is reserved for the trap.
- On accept, checks in priority order:
  1. in_tok>5 -> ERR, BAD_TOK.
  2. LOOP_END with depth==0 -> ERR, UNDERFLOW.
  3. count==PROG_SIZE-1 and !in_last -> ERR, OVERFLOW.
  4. in_last and the post-token depth is nonzero -> ERR, UNBALANCED.
- A token that fails any check is never written.
- Legal token:
  - Registered write next cycle: wr_en=1, wr_addr=count, wr_tok=in_tok.
  - count++.
  - depth++ on LOOP_BEGIN, depth-- on LOOP_END.
- Legal token with in_last: prog_len=count+1, then go to PAD.
- PAD:
  - One NOP write per cycle at addresses prog_len .. PROG_SIZE inclusive, ascending.
  - After the write to address PROG_SIZE, go to DONE; done=1, ok=1 one cycle after that final wr_en.
- ERR: done=1, ok=0, err_code held, no writes.
- In IDLE, DONE and ERR, in_valid is ignored.
- wr_en is never high for more than one address per cycle. Memory contents beyond the loader's writes are not its concern.
- depth saturation is unnecessary: it is bounded by count<=PROG_SIZE and fits in ADDR_W.
- Simultaneous start and accept in LOAD: start wins and the token is dropped; in_ready remains 1 in the following cycle.
- Reset mid-load or mid-PAD: immediate return to IDLE with all outputs cleared; partially written memory is not rolled back.

Test Plan:
- Reset with in_valid=1, in_tok=3 -> in_ready=0, wr_en=0, done=0, ok=0; no writes until start.
- start, then stream 3,2,4(last) with in_valid held high:
  - Writes (0,3), (1,2), (2,4) on consecutive cycles.
  - Then NOP writes at addresses 3..8.
  - Then done=1, ok=1, prog_len=3.
- start, then stream 4 -> no write; done=1, ok=0, err_code=1 (UNDERFLOW). Repeat with first token 7 -> err_code=0 (BAD_TOK).
- start, 8 tokens of 0 with in_last only on the 8th -> writes 0..7, a single NOP write at address 8, ok=1, prog_len=8.
  - Same stream without in_last on the 8th -> 8th not written, err_code=2 (OVERFLOW).
- start, stream 3,3,4(last) -> ERR with err_code=3 (UNBALANCED); the two legal tokens were written.
- Abort cases:
  - Mid-stream start pulse coincident with an accepted token -> that token is not written, count restarts at 0, and the next load writes from address 0.
  - rst_n low during PAD -> wr_en drops asynchronously and the block is in IDLE.
